uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver: the receive-side counterpart of the project's uart_tx.
- Accepts the asynchronous serial line, synchronises it, validates the start bit at mid-bit, and shifts in 8 data bits LSB-first.
- Checks the stop bit, then presents the byte with a single-cycle valid strobe.
- Used to get commands from the PC into the FPGA over the same UART link that carries pulse-type reports out.

Parameters:
- clk_f, 25000000: system clock frequency in Hz.
- baud, 115200: line rate in bit/s.
- CLKS_PER_BIT (localparam), clk_f/baud with integer truncation: 217 at the defaults. Must be ≥ 4.
- HALF_BIT (localparam), CLKS_PER_BIT/2: 108 at the defaults.

Ports:
- clk  input  1  system clock. Single clock domain.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line. Idles high.
- data  output  8  last correctly received byte. Held until the next good frame.
- valid  output  1  one-cycle pulse when data is updated.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous and active-high (rst), sampled on posedge clk.
  - Reset values: data=8'h00, valid=0, frame_err=0, busy=0.
  - Reset forces FSM=IDLE, bit counter=0, bit index=0, and both synchroniser flops=1.
  - Reset mid-frame aborts the frame immediately: no valid, no frame_err.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- State IDLE:
  - busy=0, cnt=0.
  - rx_s==0 moves to START with cnt=0.
- State START:
  - cnt increments each cycle.
  - At cnt==HALF_BIT-1, sample rx_s and clear cnt.
  - Sample 0: move to DATA with bit index=0.
  - Sample 1: treat as a glitch and return to IDLE. No outputs change.
- State DATA:
  - At cnt==CLKS_PER_BIT-1, sample rx_s into the shift register at position bit index (LSB-first), and clear cnt.
  - After bit index 7 is sampled, move to STOP. Otherwise increment the index.
- State STOP:
  - At cnt==CLKS_PER_BIT-1, sample rx_s.
  - Sample 1: data<=shift register, valid=1 for exactly one cycle, go to IDLE.
  - Sample 0: frame_err=1 for exactly one cycle, data unchanged, go to WAIT_HIGH.
- State WAIT_HIGH:
  - Stay until rx_s==1, then go to IDLE.
  - This stops a break (line held low) from being read as repeated start bits.
- Timing:
  - All sample points fall at mid-bit.
  - valid/frame_err assert 2 + HALF_BIT + 9*CLKS_PER_BIT clocks (±1) after the first posedge at which rx is low.
- Back-to-back frames:
  - A new start bit may begin right after the stop bit's mid-point.
  - IDLE must accept a start on the cycle after valid.
  - No frame may be lost when frames arrive at full line rate.
- There is no consumer handshake. A new frame overwrites data. The downstream logic must capture data on valid.
- valid and frame_err are never high in the same cycle.

Test Plan:
- Reset check: assert rst 3 cycles with rx=1 -> data=8'h00, valid=0, frame_err=0, busy=0. rx idle for 1000 cycles -> valid never asserts.
- Single frame: send 0x55 at 115200 baud (217 clk/bit) -> exactly one valid pulse, data=8'h55, busy low after the stop bit.
- Back-to-back frames: send 0xA3, 0x0F, 0xFF, 0x00 with no idle gap -> four valid pulses, in order 0xA3, 0x0F, 0xFF, 0x00, with no frame_err.
- Glitch rejection: drive rx low for 50 cycles, then high -> no valid, no frame_err, FSM back in IDLE. A following 0x3C frame is received correctly.
- Framing error / break: send 0x81 with the stop bit low, then hold rx low for 5 bit times -> one frame_err pulse, data keeps its previous value, no further pulses while low. After rx returns high, a 0x7E frame gives valid with data=8'h7E.
- Reset mid-frame: assert rst during data bit 4 of 0xC6 -> no valid or frame_err for that frame. A subsequent 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the serial input and the received-byte outputs of the
// 8N1 UART receiver. The receiver is the "master" of the byte bus: it drives
// data/valid/frame_err/busy and listens to rx. The "slave" side is whatever
// owns the serial line and consumes the received bytes.
interface uart_rx_if;
  logic       rx;         // asynchronous serial line, idles high
  logic [7:0] data;       // last correctly received byte
  logic       valid;      // one-cycle pulse when data is updated
  logic       frame_err;  // one-cycle pulse on a low stop bit
  logic       busy;       // receiver is not idle

  modport master (
    input  rx,
    output data,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// The serial line is double-flopped, the start bit is confirmed at its
// mid-point, then 8 data bits are sampled LSB-first at mid-bit followed by
// the stop bit. A good stop bit updates data and pulses valid; a low stop
// bit pulses frame_err and the receiver waits for the line to return high
// so that a break is not read as a train of start bits.
// All outputs are registered. There is no consumer handshake: a new frame
// simply overwrites data, so downstream logic must capture it on valid.
module uart_rx #(
  parameter int clk_f = 25000000,  // system clock frequency in Hz
  parameter int baud  = 115200     // line rate in bit/s
) (
  input  logic      clk,
  input  logic      rst,           // synchronous, active-high
  uart_rx_if.master bus
);

  // Bit period in clocks (truncated) and the offset to the middle of a bit.
  // The bit period must be at least 4 clocks for mid-bit sampling to work.
  localparam int CLKS_PER_BIT = clk_f / baud;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_e;

  // Synchroniser: sync_q[0] is the first flop, sync_q[1] is the stable rx_s.
  logic [1:0]       sync_q;
  logic             rx_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  assign rx_s = sync_q[1];

  // Bring the asynchronous line into the clock domain through two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.rx};
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: bit timing, sampling decisions and output pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        idx_d = 3'd0;
        if (rx_s == 1'b0) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Confirm the start bit at its mid-point; a high sample is a glitch.
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = CNT_ZERO;
          if (rx_s == 1'b0) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // One full bit period after the previous mid-point is the next mid-point.
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = CNT_ZERO;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Returning to IDLE at the stop bit's mid-point leaves half a bit of
      // slack before a back-to-back start bit can arrive.
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = CNT_ZERO;
          if (rx_s == 1'b1) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A held-low line (break) must go high before another start is accepted.
      ST_WAIT_HIGH: begin
        cnt_d = CNT_ZERO;
        if (rx_s == 1'b1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        idx_d   = 3'd0;
      end
    endcase

    // Registered from the next state so busy lines up with the state register.
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for the 8N1 UART receiver. The stimulus
// serialises bytes onto rx and queues the expected outcome of each frame
// (byte or framing error, plus the clock at which the pulse is due); a
// separate monitor pops and compares whenever valid or frame_err appears.
module tb_uart_rx;

  localparam int CLK_F = 25000000;
  localparam int BAUD  = 115200;
  localparam int CPB   = CLK_F / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int LAT   = 2 + HALF + 9 * CPB;

  typedef struct {
    bit         err;
    logic [7:0] d;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic [7:0] last_good = 8'h00;
  exp_t sb_q[$];

  uart_rx_if u_if ();

  uart_rx #(.clk_f(CLK_F), .baud(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (u_if.valid === 1'b1 || u_if.frame_err === 1'b1) begin
      chk("valid_and_frame_err_together", 32'(u_if.valid & u_if.frame_err), 32'd0);
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=0x%02h at cycle %0d, nothing expected",
                 u_if.valid, u_if.frame_err, u_if.data, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("pulse_kind_frame_err", 32'(u_if.frame_err), 32'(e.err));
        if (!e.err) begin
          chk("rx_data", 32'(u_if.data), 32'(e.d));
          last_good = e.d;
        end else begin
          chk("data_held_on_frame_err", 32'(u_if.data), 32'(last_good));
        end
        n_total++;
        if (cyc >= e.due - 1 && cyc <= e.due + 1) n_pass++;
        else $display("FAIL latency: pulse at cycle %0d, expected %0d (+/-1)", cyc, e.due);
      end
    end
  end

  // Hold rx at one level for a whole bit period (called at a negedge).
  task automatic drive_bit(input logic b);
    u_if.rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    u_if.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Serialise one frame and queue its expected outcome.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    e.err = !stop_ok;
    e.d   = b;
    e.due = cyc + 1 + LAT;
    sb_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok ? 1'b1 : 1'b0);
  endtask

  initial begin
    logic [7:0] c6;
    logic [7:0] rb;
    bit         ok;
    c6 = 8'hC6;
    u_if.rx = 1'b1;

    // Reset for 3 cycles with the line idle.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(u_if.data), 32'h00);
    chk("reset_valid", 32'(u_if.valid), 32'd0);
    chk("reset_frame_err", 32'(u_if.frame_err), 32'd0);
    chk("reset_busy", 32'(u_if.busy), 32'd0);
    rst = 1'b0;
    idle(1000);
    chk("idle_busy", 32'(u_if.busy), 32'd0);

    // Single frame.
    send_frame(8'h55, 1'b1);
    idle(20);
    chk("busy_after_55", 32'(u_if.busy), 32'd0);
    chk("data_after_55", 32'(u_if.data), 32'h55);

    // Back-to-back frames, no idle gap.
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    idle(CPB);

    // Glitch shorter than half a bit, then a real frame.
    u_if.rx = 1'b0;
    repeat (50) @(negedge clk);
    idle(200);
    chk("busy_after_glitch", 32'(u_if.busy), 32'd0);
    send_frame(8'h3C, 1'b1);
    idle(CPB);

    // Framing error followed by a break of 5 bit times.
    send_frame(8'h81, 1'b0);
    u_if.rx = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    chk("busy_during_break", 32'(u_if.busy), 32'd1);
    chk("data_during_break", 32'(u_if.data), 32'h3C);
    idle(2 * CPB);
    chk("busy_after_break", 32'(u_if.busy), 32'd0);
    send_frame(8'h7E, 1'b1);
    idle(CPB);

    // Reset in the middle of data bit 4; the aborted frame produces nothing.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(c6[i]);
    u_if.rx = c6[4];
    repeat (HALF) @(negedge clk);
    rst = 1'b1;
    u_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    last_good = 8'h00;
    chk("midframe_reset_data", 32'(u_if.data), 32'h00);
    chk("midframe_reset_busy", 32'(u_if.busy), 32'd0);
    rst = 1'b0;
    idle(2 * CPB);
    send_frame(8'h5A, 1'b1);
    idle(CPB);

    // Random frames: mostly good with random gaps, some with a low stop bit.
    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(rb, ok);
      if (!ok) begin
        u_if.rx = 1'b0;
        repeat ($urandom_range(0, 3) * CPB) @(negedge clk);
        idle(2 * CPB);
      end else begin
        idle($urandom_range(0, 30));
      end
    end
    idle(CPB);

    // Every queued expectation must have been matched by a pulse.
    for (int i = 0; i < 4 * CPB && sb_q.size() != 0; i++) @(negedge clk);
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected pulses never seen, required 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
